// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared fetch-stage widths, state encoding and halt word
package cpu_defs;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [INST_W-1:0] DEFAULT_HALT_INST = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    FS_BOOT = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// rtl/fetch_unit_next_pc_sel.sv - redirect priority mux producing the next pc
module next_pc_sel
  import cpu_defs::*;
(
  input  logic              id_valid,
  input  logic              jr,
  input  logic              jump,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic [25:0]       jump_target,
  input  logic [15:0]       branch_offset,
  input  logic [ADDR_W-1:0] id_pc_plus4,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] next_pc,
  output logic              redirect
);

  logic [ADDR_W-1:0] branch_disp;

  assign branch_disp = {{14{branch_offset[15]}}, branch_offset, 2'b00};

  // Redirects only count when the instruction that raised them is real.
  always_comb begin
    next_pc  = pc + 32'd4;
    redirect = 1'b0;
    if (id_valid) begin
      if (jr) begin
        next_pc  = jr_target & 32'hFFFF_FFFC;
        redirect = 1'b1;
      end else if (jump) begin
        next_pc  = {id_pc_plus4[31:28], jump_target, 2'b00};
        redirect = 1'b1;
      end else if (branch_taken) begin
        next_pc  = id_pc_plus4 + branch_disp;
        redirect = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: pc, IF/ID register, redirects, halt
module fetch_unit
  import cpu_defs::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [INST_W-1:0] HALT_INST = DEFAULT_HALT_INST
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [15:0]       branch_offset,
  input  logic              jump,
  input  logic [25:0]       jump_target,
  input  logic              jr,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic              resume,
  output logic [INST_W-1:0] id_inst,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] id_pc_plus4,
  output logic              id_valid,
  output logic              halted
);

  fetch_state_t      state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, pc_seq, sel_pc;
  logic [INST_W-1:0] inst_n;
  logic [ADDR_W-1:0] id_pc_n, id_pc_plus4_n;
  logic              valid_n, redirect;

  assign rom_addr = {2'b00, pc[31:2]};
  assign pc_seq   = pc + 32'd4;
  assign halted   = (state == FS_HALT);

  next_pc_sel u_next_pc_sel (
    .id_valid      (id_valid),
    .jr            (jr),
    .jump          (jump),
    .branch_taken  (branch_taken),
    .jr_target     (jr_target),
    .jump_target   (jump_target),
    .branch_offset (branch_offset),
    .id_pc_plus4   (id_pc_plus4),
    .pc            (pc),
    .next_pc       (sel_pc),
    .redirect      (redirect)
  );

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    inst_n        = id_inst;
    id_pc_n       = id_pc;
    id_pc_plus4_n = id_pc_plus4;
    valid_n       = id_valid;
    case (state)
      FS_BOOT: begin
        inst_n        = rom_inst;
        id_pc_n       = pc;
        id_pc_plus4_n = pc_seq;
        valid_n       = 1'b1;
        pc_n          = pc_seq;
        state_n       = FS_RUN;
      end
      FS_RUN: begin
        if (redirect) begin
          // The word fetched this cycle is on the wrong path: leave a bubble.
          pc_n    = sel_pc;
          valid_n = 1'b0;
        end else if (stall) begin
          pc_n = pc;
        end else if (rom_inst == HALT_INST) begin
          pc_n    = pc_seq;
          valid_n = 1'b0;
          state_n = FS_HALT;
        end else begin
          inst_n        = rom_inst;
          id_pc_n       = pc;
          id_pc_plus4_n = pc_seq;
          valid_n       = 1'b1;
          pc_n          = pc_seq;
        end
      end
      FS_HALT: begin
        valid_n = 1'b0;
        if (resume) state_n = FS_RUN;
      end
      default: begin
        state_n = FS_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FS_BOOT;
      pc          <= RESET_PC;
      id_inst     <= '0;
      id_pc       <= '0;
      id_pc_plus4 <= '0;
      id_valid    <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      id_inst     <= inst_n;
      id_pc       <= id_pc_n;
      id_pc_plus4 <= id_pc_plus4_n;
      id_valid    <= valid_n;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized checks of fetch_unit against a fetch model
module tb_fetch_unit;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst2_n;
  logic [31:0] rom_addr, rom_inst, id_inst, id_pc, id_pc_plus4;
  logic        id_valid, halted;
  logic [31:0] rom_addr2, rom_inst2, id_inst2, id_pc2, id_pc_plus4_2;
  logic        id_valid2, halted2;
  logic        stall, branch_taken, jump, jr, resume;
  logic [15:0] branch_offset;
  logic [25:0] jump_target;
  logic [31:0] jr_target;

  logic [31:0] mem [0:255];

  int vectors = 0;
  int errors  = 0;

  logic [31:0] m_pc, m_inst, m_id_pc, m_plus;
  bit          m_valid, m_boot, m_halt;

  // Words outside the backing array are a fixed hash of the word address.
  always_comb rom_inst  = (rom_addr  < 32'd256) ? mem[rom_addr[7:0]]  : rom_addr  * 32'h9E37_79B1;
  always_comb rom_inst2 = (rom_addr2 < 32'd256) ? mem[rom_addr2[7:0]] : rom_addr2 * 32'h9E37_79B1;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_inst(rom_inst), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset), .jump(jump),
    .jump_target(jump_target), .jr(jr), .jr_target(jr_target), .resume(resume),
    .id_inst(id_inst), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_valid(id_valid),
    .halted(halted)
  );

  fetch_unit #(.RESET_PC(32'h100)) dut2 (
    .clk(clk), .rst_n(rst2_n), .rom_addr(rom_addr2), .rom_inst(rom_inst2), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset), .jump(jump),
    .jump_target(jump_target), .jr(jr), .jr_target(jr_target), .resume(resume),
    .id_inst(id_inst2), .id_pc(id_pc2), .id_pc_plus4(id_pc_plus4_2), .id_valid(id_valid2),
    .halted(halted2)
  );

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return (a < 32'd256) ? mem[a[7:0]] : a * 32'h9E37_79B1;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_inst = 32'h0; m_id_pc = 32'h0; m_plus = 32'h0;
    m_valid = 1'b0; m_boot = 1'b1; m_halt = 1'b0;
  endtask

  // One clock of fetch behaviour, evaluated with the inputs present before the edge.
  task automatic model_step();
    logic [31:0] word, sx;
    word = rom_fn(m_pc >> 2);
    sx   = {{16{branch_offset[15]}}, branch_offset};
    if (!rst_n) model_reset();
    else if (m_boot) begin
      m_inst = word; m_id_pc = m_pc; m_plus = m_pc + 32'd4; m_valid = 1'b1;
      m_pc = m_pc + 32'd4; m_boot = 1'b0;
    end else if (m_halt) begin
      if (resume) m_halt = 1'b0;
    end else if (m_valid && jr) begin
      m_pc = jr_target & 32'hFFFF_FFFC; m_valid = 1'b0;
    end else if (m_valid && jump) begin
      m_pc = {m_plus[31:28], jump_target, 2'b00}; m_valid = 1'b0;
    end else if (m_valid && branch_taken) begin
      m_pc = m_plus + sx * 32'd4; m_valid = 1'b0;
    end else if (stall) begin
      m_valid = m_valid;
    end else if (word == HALT) begin
      m_pc = m_pc + 32'd4; m_halt = 1'b1; m_valid = 1'b0;
    end else begin
      m_inst = word; m_id_pc = m_pc; m_plus = m_pc + 32'd4; m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; branch_taken = 0; jump = 0; jr = 0; resume = 0;
    branch_offset = '0; jump_target = '0; jr_target = '0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    cycle(); cycle();
    vectors++; if (rom_addr !== 32'h0) begin errors++; $display("FAIL rst_rom_addr: got %h want %h", rom_addr, 32'h0); end
    vectors++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_id_valid: got %b want 0", id_valid); end
    vectors++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b want 0", halted); end
    vectors++; if ({id_inst, id_pc, id_pc_plus4} !== 96'h0) begin errors++; $display("FAIL rst_ifid: got %h %h %h want zeros", id_inst, id_pc, id_pc_plus4); end
    rst_n = 1;
    cycle();
    vectors++; if ({id_inst, id_pc, id_valid, rom_addr} !== {32'd0, 32'd0, 1'b1, 32'd1}) begin errors++; $display("FAIL boot_word0: got %h %h %b %h want 0 0 1 1", id_inst, id_pc, id_valid, rom_addr); end
    cycle();
    vectors++; if ({id_inst, id_pc, id_pc_plus4, rom_addr} !== {32'd1, 32'd4, 32'd8, 32'd2}) begin errors++; $display("FAIL seq_word1: got %h %h %h %h want 1 4 8 2", id_inst, id_pc, id_pc_plus4, rom_addr); end
    cycle();
    vectors++; if ({id_inst, id_pc, id_valid, rom_addr} !== {32'd2, 32'd8, 1'b1, 32'd3}) begin errors++; $display("FAIL seq_word2: got %h %h %b %h want 2 8 1 3", id_inst, id_pc, id_valid, rom_addr); end
  endtask

  task automatic test_branch();
    branch_taken = 1; branch_offset = 16'hFFFE;
    cycle();
    clear_inputs();
    vectors++; if ({rom_addr, id_valid} !== {32'd1, 1'b0}) begin errors++; $display("FAIL branch_back: got %h %b want 1 0", rom_addr, id_valid); end
    cycle();
    vectors++; if ({id_inst, id_pc, id_valid, rom_addr} !== {32'd1, 32'd4, 1'b1, 32'd2}) begin errors++; $display("FAIL branch_target: got %h %h %b %h want 1 4 1 2", id_inst, id_pc, id_valid, rom_addr); end
  endtask

  task automatic test_jump_jr();
    jr = 1; jr_target = 32'h40; jump = 1; jump_target = 26'h10;
    cycle();
    clear_inputs();
    vectors++; if ({rom_addr, id_valid} !== {32'h10, 1'b0}) begin errors++; $display("FAIL jr_priority: got %h %b want 10 0", rom_addr, id_valid); end
    cycle();
    vectors++; if ({id_inst, id_pc, id_valid} !== {32'h10, 32'h40, 1'b1}) begin errors++; $display("FAIL jr_fetch: got %h %h %b want 10 40 1", id_inst, id_pc, id_valid); end
    jr = 1; jr_target = 32'h0;
    cycle();
    clear_inputs();
    cycle();
    branch_taken = 1; branch_offset = 16'd3;
    cycle();
    clear_inputs();
    vectors++; if ({rom_addr, id_valid} !== {32'd4, 1'b0}) begin errors++; $display("FAIL branch_fwd: got %h %b want 4 0", rom_addr, id_valid); end
    jump = 1; jump_target = 26'h30;
    cycle();
    vectors++; if ({rom_addr, id_inst, id_valid} !== {32'd5, 32'd4, 1'b1}) begin errors++; $display("FAIL bubble_ignores_jump: got %h %h %b want 5 4 1", rom_addr, id_inst, id_valid); end
    cycle();
    clear_inputs();
    vectors++; if ({rom_addr, id_valid} !== {32'h30, 1'b0}) begin errors++; $display("FAIL jump_target: got %h %b want 30 0", rom_addr, id_valid); end
    cycle();
    vectors++; if ({id_inst, id_pc} !== {32'h30, 32'hC0}) begin errors++; $display("FAIL jump_fetch: got %h %h want 30 c0", id_inst, id_pc); end
  endtask

  task automatic test_stall();
    jr = 1; jr_target = 32'd8;
    cycle();
    clear_inputs();
    cycle();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      vectors++; if ({rom_addr, id_inst, id_pc, id_valid} !== {32'd3, 32'd2, 32'd8, 1'b1}) begin errors++; $display("FAIL stall_hold%0d: got %h %h %h %b want 3 2 8 1", i, rom_addr, id_inst, id_pc, id_valid); end
    end
    branch_taken = 1; branch_offset = 16'd2;
    cycle();
    clear_inputs();
    vectors++; if ({rom_addr, id_valid} !== {32'd5, 1'b0}) begin errors++; $display("FAIL stall_branch: got %h %b want 5 0", rom_addr, id_valid); end
  endtask

  task automatic test_halt();
    cycle();
    jr = 1; jr_target = 32'd16;
    cycle();
    clear_inputs();
    mem[5] = HALT;
    cycle();
    vectors++; if ({id_inst, id_pc, id_valid, rom_addr} !== {32'd4, 32'd16, 1'b1, 32'd5}) begin errors++; $display("FAIL pre_halt: got %h %h %b %h want 4 10 1 5", id_inst, id_pc, id_valid, rom_addr); end
    cycle();
    vectors++; if ({halted, id_valid, rom_addr, id_inst} !== {1'b1, 1'b0, 32'd6, 32'd4}) begin errors++; $display("FAIL halt_enter: got %b %b %h %h want 1 0 6 4", halted, id_valid, rom_addr, id_inst); end
    for (int i = 0; i < 3; i++) begin
      jr = 1; jump = 1; branch_taken = 1; stall = 1'($urandom_range(0, 1));
      jr_target = $urandom; jump_target = 26'($urandom); branch_offset = 16'($urandom);
      cycle();
      vectors++; if ({halted, id_valid, rom_addr, id_pc} !== {1'b1, 1'b0, 32'd6, 32'd16}) begin errors++; $display("FAIL halt_frozen%0d: got %b %b %h %h want 1 0 6 10", i, halted, id_valid, rom_addr, id_pc); end
    end
    clear_inputs();
    resume = 1;
    cycle();
    resume = 0;
    vectors++; if ({halted, id_valid, rom_addr} !== {1'b0, 1'b0, 32'd6}) begin errors++; $display("FAIL resume: got %b %b %h want 0 0 6", halted, id_valid, rom_addr); end
    cycle();
    vectors++; if ({id_inst, id_pc, id_valid} !== {32'd6, 32'd24, 1'b1}) begin errors++; $display("FAIL post_halt: got %h %h %b want 6 18 1", id_inst, id_pc, id_valid); end
    mem[5] = 32'd5;
  endtask

  task automatic test_wrap();
    logic [31:0] top_word;
    top_word = rom_fn(32'h3FFF_FFFF);
    jr = 1; jr_target = 32'hFFFF_FFFF;
    cycle();
    clear_inputs();
    vectors++; if (rom_addr !== 32'h3FFF_FFFF) begin errors++; $display("FAIL jr_align: got %h want 3fffffff", rom_addr); end
    cycle();
    vectors++; if ({id_inst, id_pc, id_pc_plus4, rom_addr} !== {top_word, 32'hFFFF_FFFC, 32'h0, 32'h0}) begin errors++; $display("FAIL pc_wrap: got %h %h %h %h want %h fffffffc 0 0", id_inst, id_pc, id_pc_plus4, rom_addr, top_word); end
  endtask

  task automatic test_async_reset();
    jr = 1; jr_target = 32'h20;
    cycle();
    clear_inputs();
    vectors++; if (rom_addr !== 32'h8) begin errors++; $display("FAIL pre_reset_pc: got %h want 8", rom_addr); end
    #2;
    rst_n = 0; rst2_n = 0;
    #1;
    vectors++; if ({rom_addr, id_inst, id_pc, id_pc_plus4, id_valid, halted} !== {32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0}) begin errors++; $display("FAIL async_reset: got %h %h %h %h %b %b want zeros", rom_addr, id_inst, id_pc, id_pc_plus4, id_valid, halted); end
    vectors++; if (rom_addr2 !== 32'h40) begin errors++; $display("FAIL reset_pc_param: got %h want 40", rom_addr2); end
    @(posedge clk); #1;
    cycle();
    rst_n = 1; rst2_n = 1;
    cycle();
    vectors++; if ({id_inst2, id_pc2, id_pc_plus4_2, id_valid2, halted2, rom_addr2} !== {32'h40, 32'h100, 32'h104, 1'b1, 1'b0, 32'h41}) begin errors++; $display("FAIL boot_param: got %h %h %h %b %b %h want 40 100 104 1 0 41", id_inst2, id_pc2, id_pc_plus4_2, id_valid2, halted2, rom_addr2); end
  endtask

  task automatic test_random();
    rst_n = 0;
    cycle();
    for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
    rst_n = 1;
    for (int n = 0; n < 400; n++) begin
      jr            = ($urandom_range(0, 7) == 0);
      jump          = ($urandom_range(0, 7) == 0);
      branch_taken  = ($urandom_range(0, 5) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      resume        = ($urandom_range(0, 2) == 0);
      jr_target     = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      jump_target   = 26'($urandom_range(0, 300));
      branch_offset = 16'($urandom);
      cycle();
      vectors++; if (rom_addr !== {2'b00, m_pc[31:2]}) begin errors++; $display("FAIL rnd_rom_addr@%0d: got %h want %h", n, rom_addr, {2'b00, m_pc[31:2]}); end
      vectors++; if (id_valid !== m_valid) begin errors++; $display("FAIL rnd_id_valid@%0d: got %b want %b", n, id_valid, m_valid); end
      vectors++; if (halted !== m_halt) begin errors++; $display("FAIL rnd_halted@%0d: got %b want %b", n, halted, m_halt); end
      vectors++; if (id_inst !== m_inst) begin errors++; $display("FAIL rnd_id_inst@%0d: got %h want %h", n, id_inst, m_inst); end
      vectors++; if (id_pc !== m_id_pc) begin errors++; $display("FAIL rnd_id_pc@%0d: got %h want %h", n, id_pc, m_id_pc); end
      vectors++; if (id_pc_plus4 !== m_plus) begin errors++; $display("FAIL rnd_id_pc_plus4@%0d: got %h want %h", n, id_pc_plus4, m_plus); end
    end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; rst2_n = 0;
    clear_inputs();
    for (int i = 0; i < 256; i++) mem[i] = 32'(i);
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_branch();
    test_jump_jr();
    test_stall();
    test_halt();
    test_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction ROM (ROM_A) and the decoder.
- Holds the program counter and drives the ROM word address.
- Captures the combinational ROM output into an IF/ID register with a valid bit.
- Applies redirects (branch, jump, jump-register), stalls and a halt state machine.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset; must be word aligned.
- HALT_INST, 32'hFFFF_FFFF, instruction encoding that stops fetch.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rom_addr  output  32  ROM word address = {2'b00, pc[31:2]}; combinational from pc.
- rom_inst  input  32  ROM data for rom_addr, valid in the same cycle.
- stall  input  1  hold pc and the IF/ID register.
- branch_taken  input  1  redirect to the branch target.
- branch_offset  input  16  signed word offset of the branch in IF/ID.
- jump  input  1  redirect to the J-format target.
- jump_target  input  26  J-format index field.
- jr  input  1  redirect to a register value.
- jr_target  input  32  register value (byte address).
- resume  input  1  leave the HALT state.
- id_inst  output  32  registered instruction.
- id_pc  output  32  byte address of id_inst.
- id_pc_plus4  output  32  id_pc + 4.
- id_valid  output  1  id_inst is a real instruction, not a bubble.
- halted  output  1  state == HALT.

Behaviour:
- Reset (async, rst_n low):
  - pc = RESET_PC, state = BOOT.
  - id_inst = 0, id_pc = 0, id_pc_plus4 = 0, id_valid = 0, halted = 0.
  - Reset asserted mid-operation discards everything immediately; no partial update.
- States: BOOT, RUN, HALT.
  - BOOT: exactly one cycle after reset release. Captures the first ROM word into IF/ID with id_valid = 1 and pc advances by 4; then RUN. Inputs stall, branch_taken, jump, jr and resume are ignored in BOOT.
  - RUN: normal fetch (priority list below).
  - HALT: pc and IF/ID are frozen, id_valid = 0, halted = 1. resume = 1 → RUN next cycle with fetch at the frozen pc (the instruction after the halt word). Redirects and stall are ignored in HALT.
- RUN next-state priority, highest first:
  1. jr → pc = {jr_target[31:2], 2'b00}.
  2. jump → pc = {id_pc_plus4[31:28], jump_target, 2'b00}.
  3. branch_taken → pc = id_pc_plus4 + (sign-extended branch_offset << 2); 32-bit wrap-around.
  4. stall → pc and IF/ID hold; id_valid holds its value.
  5. Otherwise → IF/ID = {rom_inst, pc, pc+4}, id_valid = 1, pc = pc + 4.
- Redirect qualification and side effects:
  - Redirect inputs are honoured only when id_valid = 1; otherwise they are ignored.
  - Any honoured redirect overrides stall.
  - On a redirect the wrong-path word in the ROM this cycle is dropped: id_valid = 0 next cycle (one-bubble penalty).
  - Simultaneous redirects resolve by the priority above.
- Halt detection:
  - In RUN with no redirect and no stall, if rom_inst == HALT_INST then pc = pc + 4, state = HALT and id_valid = 0.
  - The halt word is never presented with id_valid = 1.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0, with no flag.
- pc[1:0] is always 0; rom_addr is 0 at reset when RESET_PC = 0.
- Latency:
  - An instruction appears on id_inst one cycle after its address is on rom_addr.
  - A redirect raised in cycle N puts the target address on rom_addr in cycle N+1, and its instruction on id_inst in cycle N+2.

Decomposition:
- Shared package cpu_defs:
  - State encoding constants FS_BOOT, FS_RUN, FS_HALT.
  - Width constants INST_W = 32, ADDR_W = 32.
  - Default HALT_INST value.
- One natural sub-module, next_pc_sel: combinational priority mux that produces next pc and a redirect flag from the redirect inputs, id_pc_plus4 and pc.

Test Plan:
1. Reset with ROM word i = i, then release → rom_addr 0, 1, 2, …; id_inst 0, 1, 2 on consecutive cycles; id_pc 0, 4, 8; id_valid low only during reset.
2. Branch: id_pc = 8, branch_taken = 1, branch_offset = 16'hFFFE → next rom_addr = 1 (pc = 4); one bubble (id_valid = 0); then id_inst = word 1.
3. Jump and jr asserted together: jr_target = 32'h40, jump_target = 26'h10 → pc = 32'h40 (jr wins); branch to +3 words from id_pc = 0 → pc = 16.
4. Stall held 3 cycles at pc = 12 → rom_addr stays 3 and id_inst/id_pc unchanged; a branch during the stall still redirects.
5. HALT_INST at word 5 → halted = 1 after id_inst = word 4 and id_valid = 0; pc frozen at 24 while stimulus changes; resume pulse → id_inst = word 6.
6. Async reset asserted mid-cycle while at pc = 32'h20 → all outputs reset immediately, without waiting for a clock edge; with RESET_PC = 32'h100 fetch restarts at rom_addr = 32'h40.
